// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the MEM-stage load/store port of
//               the RV64 pipeline. One request in flight at a time, valid/
//               ready on both the request and the response channel, and a
//               fixed response latency set by a parameter. Load data comes
//               back right-justified and zero-extended. Sign extension is
//               done downstream in MEM/WB, selected by funct3.
//
// Parameters  : DEPTH_WORDS - number of 64-bit words (power of two, >= 2)
//               LATENCY     - edges from request acceptance to the edge that
//                             raises resp_valid, counted from 1 (>= 1)
//
// Ports       : clk         in   clock, rising edge
//               rst         in   synchronous reset, active-high
//               req_valid   in   request present
//               req_ready   out  responder can accept (IDLE and not in reset)
//               req_we      in   1 = store, 0 = load
//               req_size    in   0 = byte, 1 = half, 2 = word, 3 = dword
//               req_addr    in   byte address
//               req_wdata   in   store data, LSB-aligned
//               resp_valid  out  response present
//               resp_ready  in   requester takes the response
//               resp_rdata  out  load data, zero-extended; 0 for stores/errors
//               resp_err    out  misaligned or out-of-range access
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_AW = $clog2(DEPTH_WORDS);
    // Counter holds LATENCY-1 at most; keep at least one bit for LATENCY==1.
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CW-1:0]     r_cnt;

    logic [63:0]         mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_enter_resp;
    logic [c_AW-1:0]     w_word;
    logic [2:0]          w_lane;
    logic [5:0]          w_shamt;
    logic                w_oor;
    logic                w_misaligned;
    logic                w_err;
    logic [63:0]         w_mask;
    logic [63:0]         w_rword;
    logic [63:0]         w_load_result;
    logic [63:0]         w_wshift;
    logic [3:0]          w_nbytes;
    logic [7:0]          w_be;
    logic [63:0]         w_src_rdata;
    logic                w_src_err;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == ST_RESP);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_word   = req_addr[3 +: c_AW];
    assign w_lane   = req_addr[2:0];
    assign w_shamt  = {w_lane, 3'b000};
    assign w_oor    = (req_addr[63:3] >= 61'(DEPTH_WORDS));
    assign w_nbytes = 4'd1 << req_size;

    always_comb begin
        w_misaligned = 1'b0;
        w_mask       = 64'hFFFF_FFFF_FFFF_FFFF;
        case (req_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_mask       = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                w_misaligned = req_addr[0];
                w_mask       = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                w_misaligned = |req_addr[1:0];
                w_mask       = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                w_misaligned = |req_addr[2:0];
                w_mask       = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    assign w_err = w_oor || w_misaligned;

    // ------------------------------------------------------------------
    // Load path: read at the accept edge, right-justify and mask.
    // Stores and faulting accesses always return zero data.
    // ------------------------------------------------------------------
    assign w_rword       = mem[w_word];
    assign w_load_result = (req_we || w_err) ? 64'd0 : ((w_rword >> w_shamt) & w_mask);

    // ------------------------------------------------------------------
    // Store path: byte enables cover lanes [lane, lane + 2^size - 1]
    // ------------------------------------------------------------------
    assign w_wshift = req_wdata << w_shamt;

    always_comb begin
        w_be = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_be[i] = (4'(i) >= {1'b0, w_lane}) && (4'(i) < ({1'b0, w_lane} + w_nbytes));
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (w_be[i]) begin
                    mem[w_word][8*i +: 8] <= w_wshift[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The counter reaches zero on this edge.
                if (r_cnt == c_CW'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_CW'(LATENCY - 1);
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: loaded only on the edge that enters RESP.
    // With LATENCY==1 that edge is the accept edge itself, so the load
    // result feeds the output directly; otherwise it waits in a pending
    // register captured at accept.
    // ------------------------------------------------------------------
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_nxt == ST_RESP);

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_src_rdata = w_load_result;
            assign w_src_err   = w_err;
        end else begin : g_latn
            logic [63:0] r_pend_rdata;
            logic        r_pend_err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend_rdata <= 64'd0;
                    r_pend_err   <= 1'b0;
                end else if (w_accept) begin
                    r_pend_rdata <= w_load_result;
                    r_pend_err   <= w_err;
                end
            end

            assign w_src_rdata = r_pend_rdata;
            assign w_src_err   = r_pend_err;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            resp_rdata <= w_src_rdata;
            resp_err   <= w_src_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Two instances are
//               driven: index 0 with LATENCY=2, index 1 with LATENCY=1.
//               Expected data comes from a byte-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mb [2][DEPTH*8];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: an access of 2^size bytes starting at addr.
    task automatic model(input int k, input bit we, input logic [1:0] size,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output bit err);
        int n;
        int a;
        n     = 1 << size;
        err   = (addr[63:3] >= 61'(DEPTH)) || ((addr[2:0] & 3'(n - 1)) != 3'd0);
        rdata = 64'd0;
        if (!err) begin
            a = int'(addr[15:0]);
            for (int i = 0; i < n; i++) begin
                if (we) mb[k][a + i] = wdata[8*i +: 8];
                else    rdata[8*i +: 8] = mb[k][a + i];
            end
        end
    endtask

    task automatic xact(input int k, input bit we, input logic [1:0] size,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int hold, input string tag);
        logic [63:0] er;
        bit          ee;
        int          n;
        @(negedge clk);
        req_we[k]     = we;
        req_size[k]   = size;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_valid[k]  = 1'b1;
        resp_ready[k] = 1'b0;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 64'(req_ready[k]), 64'd1);
        model(k, we, size, addr, wdata, er, ee);
        @(negedge clk);
        // Accepted; scramble the request bus to show it is ignored now.
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_size[k]  = 2'($urandom);
        req_addr[k]  = {$urandom, $urandom};
        req_wdata[k] = {$urandom, $urandom};
        n = 1;
        while (resp_valid[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat(k)));
        chk({tag, " rdata"}, resp_rdata[k], er);
        chk({tag, " err"}, 64'(resp_err[k]), 64'(ee));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 64'(resp_valid[k]), 64'd1);
            chk({tag, " hold rdata"}, resp_rdata[k], er);
            chk({tag, " hold err"}, 64'(resp_err[k]), 64'(ee));
            chk({tag, " hold req_ready"}, 64'(req_ready[k]), 64'd0);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        chk({tag, " done valid"}, 64'(resp_valid[k]), 64'd0);
        chk({tag, " done req_ready"}, 64'(req_ready[k]), 64'd1);
        chk({tag, " idle rdata"}, resp_rdata[k], er);
    endtask

    // Accept a request on instance 0 and reset while it waits.
    task automatic reset_in_wait(input bit we, input logic [1:0] size,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input string tag);
        logic [63:0] er;
        bit          ee;
        int          n;
        @(negedge clk);
        req_we[0]    = we;
        req_size[0]  = size;
        req_addr[0]  = addr;
        req_wdata[0] = wdata;
        req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 64'(req_ready[0]), 64'd1);
        model(0, we, size, addr, wdata, er, ee);
        @(negedge clk);
        chk({tag, " in wait"}, 64'(resp_valid[0]), 64'd0);
        rst[0] = 1'b1;
        // Request held valid across reset must not be taken.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        chk({tag, " ready in rst"}, 64'(req_ready[0]), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk({tag, " rst valid"}, 64'(resp_valid[0]), 64'd0);
            chk({tag, " rst ready"}, 64'(req_ready[0]), 64'd0);
            chk({tag, " rst rdata"}, resp_rdata[0], 64'd0);
            chk({tag, " rst err"}, 64'(resp_err[0]), 64'd0);
        end
        rst[0]       = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk({tag, " ready after rst"}, 64'(req_ready[0]), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({tag, " no resp"}, 64'(resp_valid[0]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] er;
        bit          ee;
        logic [1:0]  sz;
        logic [63:0] ad;
        int          ln;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'd0;
            req_addr[k] = 64'd0; req_wdata[k] = 64'd0; resp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset req_ready", 64'(req_ready[k]), 64'd0);
            chk("reset resp_valid", 64'(resp_valid[k]), 64'd0);
            chk("reset rdata", resp_rdata[k], 64'd0);
            chk("reset err", 64'(resp_err[k]), 64'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Give every word a defined value in both DUT and model.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < DEPTH; w++)
                xact(k, 1'b1, 2'd3, 64'(w * 8), {$urandom, $urandom}, 0, "fill");

        // Dword store/load, byte overwrite, byte load.
        xact(0, 1'b1, 2'd3, 64'h10, 64'h1122334455667788, 0, "t1 st");
        xact(0, 1'b0, 2'd3, 64'h10, 64'd0, 0, "t1 ld");
        xact(0, 1'b1, 2'd0, 64'h13, 64'h00000000000000AB, 0, "t2 stb");
        xact(0, 1'b0, 2'd3, 64'h10, 64'd0, 0, "t2 ld");
        xact(0, 1'b0, 2'd0, 64'h13, 64'd0, 0, "t2 ldb");

        // Faulting accesses; the OOR store aliases word 0 if it leaks.
        xact(0, 1'b0, 2'd1, 64'h11, 64'd0, 0, "t3 mis");
        xact(0, 1'b0, 2'd3, 64'(DEPTH * 8), 64'd0, 0, "t3 oor ld");
        xact(0, 1'b1, 2'd3, 64'(DEPTH * 8), 64'hDEADBEEFCAFEF00D, 0, "t3 oor st");
        xact(0, 1'b0, 2'd3, 64'h0, 64'd0, 0, "t3 word0");
        xact(0, 1'b0, 2'd3, 64'h8000_0000_0000_0010, 64'd0, 0, "t3 hi oor");
        xact(0, 1'b1, 2'd2, 64'h16, 64'hFFFF_FFFF, 0, "t3 mis st");
        xact(0, 1'b0, 2'd3, 64'h10, 64'd0, 0, "t3 after");

        // Backpressure.
        xact(0, 1'b0, 2'd3, 64'h10, 64'd0, 5, "t4 bp");
        xact(1, 1'b0, 2'd2, 64'h24, 64'd0, 5, "t4 bp1");

        // Reset during WAIT: load dropped, store stays committed.
        reset_in_wait(1'b0, 2'd3, 64'h10, 64'd0, "t5 ld");
        reset_in_wait(1'b1, 2'd3, 64'h20, 64'h0123456789ABCDEF, "t5 st");
        xact(0, 1'b0, 2'd3, 64'h20, 64'd0, 0, "t5 chk");

        // LATENCY=1 back-to-back loads with resp_ready held high.
        @(negedge clk);
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom);
            ln = int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
            ad = 64'(int'($urandom_range(0, DEPTH - 1)) * 8 + ln);
            chk("t6 req_ready", 64'(req_ready[1]), 64'd1);
            chk("t6 idle valid", 64'(resp_valid[1]), 64'd0);
            req_we[1] = 1'b0; req_size[1] = sz; req_addr[1] = ad; req_valid[1] = 1'b1;
            model(1, 1'b0, sz, ad, 64'd0, er, ee);
            @(negedge clk);
            chk("t6 resp_valid", 64'(resp_valid[1]), 64'd1);
            chk("t6 rdata", resp_rdata[1], er);
            chk("t6 err", 64'(resp_err[1]), 64'(ee));
            chk("t6 busy", 64'(req_ready[1]), 64'd0);
            @(negedge clk);
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b0;

        // Randomized mix of sizes, lanes, stores/loads and faults.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                sz = 2'($urandom);
                ln = int'($urandom_range(0, 7));
                if ($urandom_range(0, 4) != 0) ln = ln & ~((1 << sz) - 1);
                ad = 64'(int'($urandom_range(0, DEPTH + 1)) * 8 + ln);
                xact(k, 1'($urandom), sz, ad, {$urandom, $urandom},
                     int'($urandom_range(0, 2)), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
